// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode encoding, default width and NZCV flag layout for alu_core.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_MUL = 4'd2,
        ALU_OR  = 4'd3,
        ALU_LSL = 4'd4,
        ALU_LSR = 4'd5
    } alu_op_e;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } alu_flags_t;

endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: combinational logical shift left/right returning the value and the last bit shifted out.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int SW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [SW-1:0]    sh,
    input  logic             left,
    output logic [WIDTH-1:0] y,
    output logic             c
);

    // One guard bit on the exit side catches the carry; a zero shift leaves it clear.
    logic [WIDTH:0] l, r;

    assign l = {1'b0, a} << sh;
    assign r = {a, 1'b0} >> sh;
    assign y = left ? l[WIDTH-1:0] : r[WIDTH:1];
    assign c = left ? l[WIDTH] : r[0];

endmodule

// File: rtl/alu_core.sv
// alu_core: registered integer ALU (add/sub/mul/or/lsl/lsr) with an NZCV flag register loaded on set.
// Define ALU_MUL_EN to build the multiplier; otherwise opcode 2 acts as an undefined opcode.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] dat1,
    input  logic [WIDTH-1:0] dat2,
    input  logic [3:0]       control,
    input  logic             set,
    output logic             Z,
    output logic             N,
    output logic             C,
    output logic             V,
    output logic [WIDTH-1:0] result
);

    localparam int SW = $clog2(WIDTH);

    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] shv, nxt;
    logic             shc, cy, ov;
    alu_flags_t       flags, nf;

    assign sum  = {1'b0, dat1} + {1'b0, dat2};
    assign diff = {1'b0, dat1} - {1'b0, dat2};

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] prod;
    assign prod = {{WIDTH{1'b0}}, dat1} * {{WIDTH{1'b0}}, dat2};
`endif

    alu_shifter #(.WIDTH(WIDTH), .SW(SW)) u_shifter (
        .a    (dat1),
        .sh   (dat2[SW-1:0]),
        .left (control == ALU_LSL),
        .y    (shv),
        .c    (shc)
    );

    always_comb begin
        nxt = '0;
        cy  = 1'b0;
        ov  = 1'b0;
        case (control)
            ALU_ADD: begin
                nxt = sum[WIDTH-1:0];
                cy  = sum[WIDTH];
                ov  = (dat1[WIDTH-1] == dat2[WIDTH-1]) && (sum[WIDTH-1] != dat1[WIDTH-1]);
            end
            ALU_SUB: begin
                nxt = diff[WIDTH-1:0];
                cy  = ~diff[WIDTH];
                ov  = (dat1[WIDTH-1] != dat2[WIDTH-1]) && (diff[WIDTH-1] != dat1[WIDTH-1]);
            end
`ifdef ALU_MUL_EN
            ALU_MUL: begin
                nxt = prod[WIDTH-1:0];
                ov  = |prod[2*WIDTH-1:WIDTH];
            end
`endif
            ALU_OR:  nxt = dat1 | dat2;
            ALU_LSL, ALU_LSR: begin
                nxt = shv;
                cy  = shc;
            end
            default: ;
        endcase
    end

    assign nf = '{z: nxt == '0, n: nxt[WIDTH-1], c: cy, v: ov};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
            flags  <= '0;
        end else begin
            result <= nxt;
            if (set) flags <= nf;
        end
    end

    assign {Z, N, C, V} = flags;

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed vector table plus randomized run against an arithmetic reference model.
module tb_alu_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] dat1 = '0, dat2 = '0;
    logic [3:0]  control = '0;
    logic        set = 1'b0;
    logic        Z, N, C, V;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    alu_core dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .dat1    (dat1),
        .dat2    (dat2),
        .control (control),
        .set     (set),
        .Z       (Z),
        .N       (N),
        .C       (C),
        .V       (V),
        .result  (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic        set;
        logic [31:0] res;
        logic [3:0]  zncv;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end
    endtask

    task automatic step(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b, input logic s);
        control = ctl;
        dat1 = a;
        dat2 = b;
        set = s;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference: wide arithmetic from the operation definitions.
    logic [3:0] mflags;

    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic c, output logic v);
        logic [63:0] w;
        longint      s;
        int          sh;
        res = 0; c = 0; v = 0;
        sh = int'(b % 32);
        case (op)
            0: begin
                w = 64'(a) + 64'(b);
                res = w[31:0]; c = w[32];
                s = longint'($signed(a)) + longint'($signed(b));
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            1: begin
                w = 64'(a) - 64'(b);
                res = w[31:0]; c = (a >= b);
                s = longint'($signed(a)) - longint'($signed(b));
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
`ifdef ALU_MUL_EN
            2: begin
                w = 64'(a) * 64'(b);
                res = w[31:0]; v = (w >> 32) != 0;
            end
`endif
            3: res = a | b;
            4: begin
                w = 64'(a) << sh;
                res = w[31:0]; c = (sh != 0) && w[32];
            end
            5: begin
                res = a >> sh;
                c = (sh != 0) && ((a >> (sh - 1)) & 32'd1) != 0;
            end
            default: ;
        endcase
    endtask

    initial begin
        vecs[0]  = '{4'd0, 32'd4, 32'd4, 1'b1, 32'd8, 4'b0000};
        vecs[1]  = '{4'd1, 32'd4, 32'd4, 1'b1, 32'd0, 4'b1010};
        vecs[2]  = '{4'd3, 32'd4, 32'd0, 1'b0, 32'd4, 4'b1010};
        vecs[3]  = '{4'd4, 32'd256, 32'd4, 1'b1, 32'd4096, 4'b0000};
        vecs[4]  = '{4'd5, 32'd256, 32'd4, 1'b1, 32'd16, 4'b0000};
        vecs[5]  = '{4'd0, 32'h7FFFFFFF, 32'd1, 1'b1, 32'h80000000, 4'b0101};
        vecs[6]  = '{4'd0, 32'hFFFFFFFF, 32'd1, 1'b1, 32'd0, 4'b1010};
        vecs[7]  = '{4'd1, 32'd3, 32'd1, 1'b0, 32'd2, 4'b1010};
        vecs[8]  = '{4'd4, 32'h80000001, 32'd1, 1'b1, 32'd2, 4'b0010};
        vecs[9]  = '{4'd5, 32'h80000001, 32'd0, 1'b1, 32'h80000001, 4'b0100};
        vecs[10] = '{4'd9, 32'd5, 32'd5, 1'b1, 32'd0, 4'b1000};
`ifdef ALU_MUL_EN
        vecs[11] = '{4'd2, 32'd4, 32'd4, 1'b1, 32'd16, 4'b0000};
        vecs[12] = '{4'd2, 32'h10000, 32'h10000, 1'b1, 32'd0, 4'b1001};
`else
        vecs[11] = '{4'd2, 32'd4, 32'd4, 1'b1, 32'd0, 4'b1000};
        vecs[12] = '{4'd2, 32'h10000, 32'h10000, 1'b1, 32'd0, 4'b1000};
`endif
        vecs[13] = '{4'd4, 32'd3, 32'h21, 1'b1, 32'd6, 4'b0000};
        vecs[14] = '{4'd1, 32'd1, 32'd2, 1'b1, 32'hFFFFFFFF, 4'b0100};
        vecs[15] = '{4'd1, 32'h80000000, 32'd1, 1'b1, 32'h7FFFFFFF, 4'b0011};

        #2;
        chk("reset_result", result, 32'd0);
        chk("reset_flags", 32'({Z, N, C, V}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].ctl, vecs[i].a, vecs[i].b, vecs[i].set);
            chk($sformatf("vec%0d_result", i), result, vecs[i].res);
            chk($sformatf("vec%0d_flags", i), 32'({Z, N, C, V}), 32'(vecs[i].zncv));
        end

        // Asynchronous reset mid-run, held across an edge, then released.
        step(4'd0, 32'hFFFFFFFF, 32'd1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_result", result, 32'd0);
        chk("async_rst_flags", 32'({Z, N, C, V}), 32'd0);
        step(4'd0, 32'd10, 32'd20, 1'b1);
        chk("held_rst_result", result, 32'd0);
        chk("held_rst_flags", 32'({Z, N, C, V}), 32'd0);
        rst_n = 1'b1;
        step(4'd0, 32'd10, 32'd20, 1'b1);
        chk("post_rst_result", result, 32'd30);
        chk("post_rst_flags", 32'({Z, N, C, V}), 32'd0);

        mflags = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a, b, er;
            logic [3:0]  op;
            logic        s, ec, ev;
            op = (i % 4 == 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 5));
            a = $urandom;
            b = $urandom;
            if (i % 7 == 0) a = (i % 2) ? 32'hFFFFFFFF : 32'h80000000;
            if (i % 5 == 0) b = 32'($urandom_range(0, 3));
            if (i % 11 == 0) b = a;
            s = 1'($urandom);
            model(op, a, b, er, ec, ev);
            if (s) mflags = {er == 0, er[31], ec, ev};
            step(op, a, b, s);
            chk($sformatf("rnd%0d_op%0d_result", i, op), result, er);
            chk($sformatf("rnd%0d_op%0d_flags", i, op), 32'({Z, N, C, V}), 32'(mflags));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
